bus_arbiter: RTL and testbench
==============================

# bus_arbiter

Round-robin arbiter that shares the single external bus master port among `N_MASTERS` harts in a multi-core build. Each hart-side port carries the same bus protocol the core top emits. Requests are sequenced one transaction at a time onto the shared slave bus. A per-master lock input lets a hart keep ownership across back-to-back transactions for atomic sequences. The block sits between the `RISC_V_` core instances and the system interconnect.

## Interface
- `N_MASTERS`, 2: number of requesting harts (2..8).
- `XLEN`, `` `XLEN ``: data/address width.
- `i_clk` in 1: clock, all state on rising edge.
- `i_rst` in 1: asynchronous reset, active-low.
- `i_m_bus_en` in N_MASTERS: per-master request, held high until acked.
- `i_m_wr_en` in N_MASTERS: per-master write strobe.
- `i_m_lock` in N_MASTERS: request to keep ownership after the current ack.
- `i_m_addr` in N_MASTERS*XLEN: packed addresses, master i at bits [i*XLEN +: XLEN].
- `i_m_wr_data` in N_MASTERS*XLEN: packed write data.
- `i_m_byte_en` in N_MASTERS*4: packed byte enables.
- `o_m_ack` out N_MASTERS: per-master ack pulse.
- `o_m_rd_data` out XLEN: read data, broadcast to all masters; valid only with that master's ack.
- `o_bus_en` out 1: shared bus request.
- `o_wr_en` out 1: shared write strobe.
- `o_addr` out XLEN: shared address.
- `o_wr_data` out XLEN: shared write data.
- `o_byte_en` out 4: shared byte enables.
- `i_ack` in 1: slave completion pulse.
- `i_rd_data` in XLEN: slave read data.

## Operation
- State registers: `state` (IDLE, BUSY, LOCKED), `grant` (clog2(N_MASTERS) bits), `rr_ptr` (same width).
- IDLE:
  - If any `i_m_bus_en` is high, select the first requester at or after `rr_ptr`, searching upward with wrap from N_MASTERS-1 to 0.
  - Register that index in `grant`; next state BUSY.
  - With no request, stay in IDLE.
- BUSY:
  - `o_bus_en` = 1.
  - `o_wr_en`, `o_addr`, `o_wr_data` and `o_byte_en` are forwarded combinationally from master `grant`.
  - `o_m_ack[grant]` = `i_ack`; `o_m_rd_data` = `i_rd_data` at all times.
- BUSY exits:
  - On `i_ack` with `i_m_lock[grant]` = 0: `rr_ptr` <= grant+1 (wrapping modulo N_MASTERS); next state IDLE.
  - On `i_ack` with `i_m_lock[grant]` = 1: `rr_ptr` unchanged; next state LOCKED.
  - If `i_m_bus_en[grant]` drops without `i_ack` (protocol violation, abort): next state IDLE, `rr_ptr` <= grant+1, no ack generated.
- LOCKED:
  - Shared outputs = 0.
  - If `i_m_bus_en[grant]` is high, next state BUSY with the same `grant`.
  - Else if `i_m_lock[grant]` is low, next state IDLE.
  - Other masters are never granted while LOCKED.
- Ignored inputs:
  - `i_ack` in IDLE or LOCKED is ignored; `o_m_ack` stays 0.
  - Lock asserted by a non-granted master has no effect until that master is granted.
- Reset (asynchronous, any state):
  - state=IDLE, grant=0, rr_ptr=0.
  - All outputs 0 (`o_m_rd_data` follows `i_rd_data`, forced 0 during reset).
- Only one `o_m_ack` bit may ever be high. Shared outputs are 0 outside BUSY.

## Timing
- Grant latency: request seen in IDLE at cycle 0 → `o_bus_en` high at cycle 1.
- Ack pass-through: `i_ack` at cycle k → `o_m_ack[grant]` at cycle k (same cycle). The master must drop or renew its request by cycle k+1.
- Turnaround:
  - Unlocked: ack at k → IDLE at k+1 → next grant's `o_bus_en` at k+2.
  - Locked: ack at k → LOCKED at k+1 → master's new request seen at k+1 → `o_bus_en` at k+2.
- Master request at cycle k+1 after its own unlocked ack is arbitrated fresh. That master has lowest priority then.
- A zero-wait slave (`i_ack` in the first BUSY cycle) is legal.

## Structure
- Shared package `arvi_bus_pkg`:
  - `arb_state_t` enum (IDLE, BUSY, LOCKED).
  - `BYTE_EN_W` = 4.
  - `GRANT_W(n)` = $clog2(n) helper, min 1.
- Sub-module `rr_pick`: combinational round-robin selector. Inputs are the request vector and `rr_ptr`; outputs are `valid` and `index`. Reusable by a future L2 arbiter.

## Test plan
- Single master: master 0 requests a read of addr 0x100; slave acks at cycle 3 with 0xDEADBEEF → `o_bus_en` cycles 1–3, `o_m_ack`=01 at cycle 3, `o_m_rd_data`=0xDEADBEEF.
- Contention, N=2: both request from reset → master 0 served first, master 1's `o_bus_en` starts 2 cycles after master 0's ack. Both request again → master 1 then master 0 (alternation over 8 transactions).
- Lock: master 1 holds `i_m_lock` across two writes (0x200, 0x204) while master 0 requests continuously → master 0 is not granted until lock drops; state returns to IDLE, then master 0 is granted.
- Abort: the granted master drops `i_m_bus_en` in BUSY with no `i_ack` → `o_bus_en` = 0 next cycle, no ack, `rr_ptr` advanced.
- Spurious ack: `i_ack` pulsed in IDLE → `o_m_ack` stays 0, state unchanged.
- Reset mid-transaction: `i_rst` low in BUSY → all outputs 0 immediately. After release, master 0 is granted first.

Source files
------------

// File: rtl/arvi_bus_pkg.sv
// Shared types and sizing helpers for the hart-side bus arbiter and related blocks.
package arvi_bus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY   = 2'd1,
    LOCKED = 2'd2
  } arb_state_t;

  localparam int BYTE_EN_W = 4;

  function automatic int GRANT_W(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request at or after i_ptr, wrapping.
module rr_pick
  import arvi_bus_pkg::*;
#(
  parameter int N = 2,
  parameter int W = GRANT_W(N)
) (
  input  logic [N-1:0] i_req,
  input  logic [W-1:0] i_ptr,
  output logic         o_valid,
  output logic [W-1:0] o_index
);

  logic [W:0] w_idx;

  // Scan from the farthest offset down so the nearest requester is written last.
  always_comb begin
    o_valid = 1'b0;
    o_index = '0;
    w_idx   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      w_idx = {1'b0, i_ptr} + (W + 1)'(k);
      if (w_idx >= (W + 1)'(N)) w_idx = w_idx - (W + 1)'(N);
      if (i_req[w_idx[W-1:0]]) begin
        o_valid = 1'b1;
        o_index = w_idx[W-1:0];
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter sharing one bus master port among N_MASTERS harts, with per-master lock.
module bus_arbiter
  import arvi_bus_pkg::*;
#(
  parameter int N_MASTERS = 2,
  parameter int XLEN      = 32
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic [N_MASTERS-1:0]           i_m_bus_en,
  input  logic [N_MASTERS-1:0]           i_m_wr_en,
  input  logic [N_MASTERS-1:0]           i_m_lock,
  input  logic [N_MASTERS*XLEN-1:0]      i_m_addr,
  input  logic [N_MASTERS*XLEN-1:0]      i_m_wr_data,
  input  logic [N_MASTERS*BYTE_EN_W-1:0] i_m_byte_en,
  output logic [N_MASTERS-1:0]           o_m_ack,
  output logic [XLEN-1:0]                o_m_rd_data,
  output logic                           o_bus_en,
  output logic                           o_wr_en,
  output logic [XLEN-1:0]                o_addr,
  output logic [XLEN-1:0]                o_wr_data,
  output logic [BYTE_EN_W-1:0]           o_byte_en,
  input  logic                           i_ack,
  input  logic [XLEN-1:0]                i_rd_data
);

  localparam int            GW   = GRANT_W(N_MASTERS);
  localparam logic [GW-1:0] LAST = GW'(N_MASTERS - 1);

  arb_state_t    r_state, w_state_nxt;
  logic [GW-1:0] r_grant, w_grant_nxt;
  logic [GW-1:0] r_rr_ptr, w_rr_nxt;
  logic [GW-1:0] w_pick_idx, w_grant_inc;
  logic          w_pick_vld, w_gnt_req, w_gnt_lock;

  rr_pick #(
    .N(N_MASTERS),
    .W(GW)
  ) u_pick (
    .i_req  (i_m_bus_en),
    .i_ptr  (r_rr_ptr),
    .o_valid(w_pick_vld),
    .o_index(w_pick_idx)
  );

  assign w_grant_inc = (r_grant == LAST) ? '0 : r_grant + 1'b1;
  assign w_gnt_req   = i_m_bus_en[r_grant];
  assign w_gnt_lock  = i_m_lock[r_grant];

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state  <= IDLE;
      r_grant  <= '0;
      r_rr_ptr <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_grant  <= w_grant_nxt;
      r_rr_ptr <= w_rr_nxt;
    end
  end

  // A locked ack keeps rr_ptr so priority only moves once the holder lets go.
  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_rr_nxt    = r_rr_ptr;
    case (r_state)
      IDLE: begin
        if (w_pick_vld) begin
          w_grant_nxt = w_pick_idx;
          w_state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (i_ack) begin
          if (w_gnt_lock) begin
            w_state_nxt = LOCKED;
          end else begin
            w_state_nxt = IDLE;
            w_rr_nxt    = w_grant_inc;
          end
        end else if (!w_gnt_req) begin
          w_state_nxt = IDLE;
          w_rr_nxt    = w_grant_inc;
        end
      end
      LOCKED: begin
        if (w_gnt_req)       w_state_nxt = BUSY;
        else if (!w_gnt_lock) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    o_bus_en  = 1'b0;
    o_wr_en   = 1'b0;
    o_addr    = '0;
    o_wr_data = '0;
    o_byte_en = '0;
    o_m_ack   = '0;
    if (r_state == BUSY) begin
      o_bus_en         = 1'b1;
      o_wr_en          = i_m_wr_en[r_grant];
      o_addr           = i_m_addr[int'(r_grant)*XLEN +: XLEN];
      o_wr_data        = i_m_wr_data[int'(r_grant)*XLEN +: XLEN];
      o_byte_en        = i_m_byte_en[int'(r_grant)*BYTE_EN_W +: BYTE_EN_W];
      o_m_ack[r_grant] = i_ack;
    end
  end

  assign o_m_rd_data = i_rst ? i_rd_data : '0;

  a_ack_onehot : assert property (@(posedge i_clk) disable iff (!i_rst) $onehot0(o_m_ack));
  a_idle_quiet : assert property (@(posedge i_clk) disable iff (!i_rst)
                                  (r_state != BUSY) |-> (!o_bus_en && o_m_ack == '0));

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter with two masters: single read, contention, lock, abort, resets.
module tb_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  bus_en, wr_en, lock, m_ack;
  logic [63:0] addr, wdata;
  logic [7:0]  be;
  logic        ack;
  logic [31:0] rdata, m_rd, o_addr, o_wdata;
  logic        o_bus_en, o_wr;
  logic [3:0]  o_be;

  int nerr = 0;
  int nchk = 0;

  always #5 clk = ~clk;

  bus_arbiter #(.N_MASTERS(2), .XLEN(32)) dut (
    .i_clk      (clk),
    .i_rst      (rst_n),
    .i_m_bus_en (bus_en),
    .i_m_wr_en  (wr_en),
    .i_m_lock   (lock),
    .i_m_addr   (addr),
    .i_m_wr_data(wdata),
    .i_m_byte_en(be),
    .o_m_ack    (m_ack),
    .o_m_rd_data(m_rd),
    .o_bus_en   (o_bus_en),
    .o_wr_en    (o_wr),
    .o_addr     (o_addr),
    .o_wr_data  (o_wdata),
    .o_byte_en  (o_be),
    .i_ack      (ack),
    .i_rd_data  (rdata)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1 chk("rst_bus_en", 32'(o_bus_en), 0);
    chk("rst_ack", 32'(m_ack), 0);
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_m;
    rst_n  = 1'b0;
    bus_en = '0; wr_en = '0; lock = '0; ack = 1'b0;
    addr   = {32'h2000, 32'h1000};
    wdata  = '0;
    be     = {4'h3, 4'hF};
    rdata  = 32'h1234_5678;
    #2;
    chk("rst_rd_forced0", m_rd, 0);
    chk("rst_bus_en0", 32'(o_bus_en), 0);
    chk("rst_addr0", o_addr, 0);
    chk("rst_ack0", 32'(m_ack), 0);
    tick();
    rst_n = 1'b1;
    #1 chk("rst_rd_follow", m_rd, 32'h1234_5678);

    // single master read of 0x100, slave acks in the third BUSY cycle
    tick();
    addr[31:0] = 32'h100;
    bus_en     = 2'b01;
    #1 chk("sgl_c0_bus_en", 32'(o_bus_en), 0);
    tick();
    chk("sgl_c1_bus_en", 32'(o_bus_en), 1);
    chk("sgl_c1_addr", o_addr, 32'h100);
    chk("sgl_c1_be", 32'(o_be), 32'hF);
    chk("sgl_c1_wr", 32'(o_wr), 0);
    chk("sgl_c1_ack", 32'(m_ack), 0);
    tick();
    chk("sgl_c2_bus_en", 32'(o_bus_en), 1);
    tick();
    ack = 1'b1; rdata = 32'hDEAD_BEEF;
    #1 chk("sgl_c3_bus_en", 32'(o_bus_en), 1);
    chk("sgl_c3_ack", 32'(m_ack), 32'b01);
    chk("sgl_c3_rd", m_rd, 32'hDEAD_BEEF);
    tick();
    ack = 1'b0; bus_en = 2'b00;
    #1 chk("sgl_c4_bus_en", 32'(o_bus_en), 0);

    // contention from reset, both masters renew immediately after every ack
    do_reset();
    addr   = {32'h2000, 32'h1000};
    bus_en = 2'b11;
    tick();
    for (int t = 0; t < 8; t++) begin
      exp_m = t % 2;
      #1 chk("cont_bus_en", 32'(o_bus_en), 1);
      chk("cont_addr", o_addr, (exp_m == 1) ? 32'h2000 : 32'h1000);
      if (exp_m == 1) begin
        tick();
        #1 chk("cont_wait_ack", 32'(m_ack), 0);
      end
      ack   = 1'b1;
      rdata = 32'hC0DE_0000 + 32'(t);
      #1 chk("cont_ack", 32'(m_ack), 32'(1) << exp_m);
      chk("cont_rd", m_rd, 32'hC0DE_0000 + 32'(t));
      tick();
      ack = 1'b0;
      if (t == 7) bus_en = 2'b00;
      #1 chk("cont_gap", 32'(o_bus_en), 0);
      tick();
    end
    #1 chk("cont_done_idle", 32'(o_bus_en), 0);

    // lock: master 1 keeps ownership over two writes while master 0 waits
    addr[63:32]  = 32'h200;
    wdata[63:32] = 32'hA5A5_0001;
    wr_en  = 2'b10;
    lock   = 2'b10;
    bus_en = 2'b10;
    tick();
    bus_en = 2'b11;
    #1 chk("lk_w1_bus_en", 32'(o_bus_en), 1);
    chk("lk_w1_addr", o_addr, 32'h200);
    chk("lk_w1_wr", 32'(o_wr), 1);
    chk("lk_w1_wdata", o_wdata, 32'hA5A5_0001);
    ack = 1'b1;
    #1 chk("lk_w1_ack", 32'(m_ack), 32'b10);
    tick();
    ack = 1'b0;
    addr[63:32]  = 32'h204;
    wdata[63:32] = 32'hA5A5_0002;
    #1 chk("lk_locked_quiet", 32'(o_bus_en), 0);
    chk("lk_locked_addr0", o_addr, 0);
    tick();
    #1 chk("lk_w2_bus_en", 32'(o_bus_en), 1);
    chk("lk_w2_addr", o_addr, 32'h204);
    chk("lk_w2_wdata", o_wdata, 32'hA5A5_0002);
    ack = 1'b1;
    #1 chk("lk_w2_ack", 32'(m_ack), 32'b10);
    tick();
    ack    = 1'b0;
    bus_en = 2'b01;
    #1 chk("lk_hold1", 32'(o_bus_en), 0);
    tick();
    #1 chk("lk_hold2", 32'(o_bus_en), 0);
    lock = 2'b00;
    tick();
    #1 chk("lk_release_idle", 32'(o_bus_en), 0);
    tick();
    #1 chk("lk_m0_bus_en", 32'(o_bus_en), 1);
    chk("lk_m0_addr", o_addr, 32'h1000);
    ack = 1'b1;
    #1 chk("lk_m0_ack", 32'(m_ack), 32'b01);
    tick();
    ack = 1'b0; bus_en = 2'b00; wr_en = 2'b00;
    addr[63:32] = 32'h2000;
    #1 chk("lk_end_idle", 32'(o_bus_en), 0);

    // spurious ack in IDLE
    ack = 1'b1;
    #1 chk("spur_ack", 32'(m_ack), 0);
    chk("spur_bus_en", 32'(o_bus_en), 0);
    tick();
    ack = 1'b0;
    #1 chk("spur_still_idle", 32'(o_bus_en), 0);

    // abort: master 1 (rr_ptr=1) drops its request mid-BUSY
    bus_en = 2'b10;
    tick();
    #1 chk("abt_bus_en", 32'(o_bus_en), 1);
    chk("abt_addr", o_addr, 32'h2000);
    bus_en = 2'b00;
    #1 chk("abt_no_ack", 32'(m_ack), 0);
    tick();
    #1 chk("abt_drop", 32'(o_bus_en), 0);
    chk("abt_no_ack2", 32'(m_ack), 0);
    bus_en = 2'b11;
    tick();
    #1 chk("abt_rr_adv", o_addr, 32'h1000);
    ack = 1'b1;
    #1;
    tick();
    ack = 1'b0;
    tick();
    #1 chk("rst_pre_m1", o_addr, 32'h2000);

    // reset while master 1 is in BUSY
    rdata = 32'h55AA_55AA;
    ack   = 1'b1;
    rst_n = 1'b0;
    #1 chk("mrst_bus_en", 32'(o_bus_en), 0);
    chk("mrst_ack", 32'(m_ack), 0);
    chk("mrst_addr", o_addr, 0);
    chk("mrst_rd", m_rd, 0);
    ack = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    tick();
    #1 chk("mrst_m0_first", o_addr, 32'h1000);
    chk("mrst_bus_en1", 32'(o_bus_en), 1);
    chk("mrst_rd_follow", m_rd, 32'h55AA_55AA);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
